// File: rtl/sync_down_counter_timer.sv
// WIDTH-bit down-counter/timer: a start value loaded over valid/ready counts to zero, pulses tc, then reloads or stops.
// All outputs are registered or decoded from state; load_ready is low while counting (RUN/PAUSED).
module sync_down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_RUN    = 2'd2,
    ST_PAUSED = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  logic load_acc;
  logic q_is_zero;
  logic q_is_one;

  assign load_acc  = load_valid && load_ready;
  assign q_is_zero = (q_q == '0);
  assign q_is_one  = (q_q == WIDTH'(1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort beats load, load beats start, start beats pause
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (load_acc) begin
      state_d = ST_LOADED;
    end else begin
      case (state_q)
        ST_LOADED: begin
          if (start) begin
            state_d = q_is_zero ? ST_IDLE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (q_is_one && !auto_reload) begin
            state_d = ST_IDLE;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    load_ready = (state_q == ST_IDLE) || (state_q == ST_LOADED);
    busy       = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  end

  // Datapath next values
  always_comb begin
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    done_d   = done_q;
    if (abort) begin
      q_d    = '0;
      done_d = 1'b0;
    end else if (load_acc) begin
      q_d      = load_value;
      reload_d = load_value;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        ST_LOADED: begin
          // Starting from zero terminates immediately without any reload
          if (start && q_is_zero) begin
            tc_d   = 1'b1;
            done_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (!pause) begin
            if (q_is_zero) begin
              q_d = reload_q;
            end else if (q_is_one) begin
              q_d  = '0;
              tc_d = 1'b1;
              if (!auto_reload) begin
                done_d = 1'b1;
              end
            end else begin
              q_d = q_q - WIDTH'(1);
            end
          end
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  assign Q    = q_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: tb/tb_sync_down_counter_timer.sv
// Scoreboard bench for sync_down_counter_timer: expectations queued with each driven cycle, compared per task.
module tb_sync_down_counter_timer;

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       done;
    logic       busy;
    logic       rdy;
  } obs_t;

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_value;
  logic       start;
  logic       pause;
  logic       abort;
  logic       auto_reload;
  logic [3:0] Q;
  logic       busy;
  logic       tc;
  logic       done;

  int passed = 0;
  int total  = 0;

  obs_t sb[$];
  obs_t obs_q[$];

  sync_down_counter_timer #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .auto_reload(auto_reload),
    .Q          (Q),
    .busy       (busy),
    .tc         (tc),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] q, input logic t, input logic d,
                              input logic b, input logic r);
    obs_t o;
    o.q = q; o.tc = t; o.done = d; o.busy = b; o.rdy = r;
    return o;
  endfunction

  function automatic obs_t cur();
    return mk(Q, tc, done, busy, load_ready);
  endfunction

  // Drive one cycle of inputs at the falling edge, queue the expectation, capture after the rising edge
  task automatic cyc(input logic lv, input logic [3:0] val, input logic st, input logic pa,
                     input logic ab, input logic ar, input obs_t e);
    @(negedge clk);
    load_valid = lv; load_value = val; start = st; pause = pa; abort = ab; auto_reload = ar;
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back(cur());
  endtask

  task automatic test_reset;
    obs_t e, o;
    reset = 1'b1;
    load_valid = 0; load_value = 0; start = 0; pause = 0; abort = 0; auto_reload = 0;
    #2 reset = 1'b0;
    #1;
    e = mk(4'd0, 0, 0, 0, 1); o = cur(); total++;
    if (o !== e) $display("FAIL reset_initial: got %h required %h", o, e); else passed++;
    repeat (2) @(posedge clk);
    #1;
    o = cur(); total++;
    if (o !== e) $display("FAIL reset_held: got %h required %h", o, e); else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_one_shot;
    obs_t e, o;
    int n;
    cyc(1, 4'd3, 0, 0, 0, 0, mk(4'd3, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, 0, 0, mk(4'd3, 0, 0, 1, 0));
    cyc(0, 4'd0, 0, 0, 0, 0, mk(4'd2, 0, 0, 1, 0));
    cyc(0, 4'd0, 0, 0, 0, 0, mk(4'd1, 0, 0, 1, 0));
    cyc(0, 4'd0, 0, 0, 0, 0, mk(4'd0, 1, 1, 0, 1));
    cyc(0, 4'd0, 0, 0, 0, 0, mk(4'd0, 0, 1, 0, 1));
    n = 0;
    while (sb.size() > 0 && obs_q.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL one_shot[%0d]: got %h required %h", n, o, e); else passed++;
      n++;
    end
  endtask

  task automatic test_periodic;
    obs_t e, o;
    int n;
    logic [3:0] qe;
    cyc(1, 4'd2, 0, 0, 0, 1, mk(4'd2, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, 0, 1, mk(4'd2, 0, 0, 1, 0));
    for (int k = 1; k <= 9; k++) begin
      qe = 4'(2 - (k % 3));
      cyc(0, 4'd0, 0, 0, 0, 1, mk(qe, (qe == 4'd0), 0, 1, 0));
    end
    cyc(0, 4'd0, 0, 0, 1, 1, mk(4'd0, 0, 0, 0, 1));
    n = 0;
    while (sb.size() > 0 && obs_q.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL periodic[%0d]: got %h required %h", n, o, e); else passed++;
      n++;
    end
  endtask

  task automatic test_pause;
    obs_t e, o;
    int n;
    cyc(1, 4'd3, 0, 0, 0, 0, mk(4'd3, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, 0, 0, mk(4'd3, 0, 0, 1, 0));
    cyc(0, 4'd0, 0, 0, 0, 0, mk(4'd2, 0, 0, 1, 0));
    cyc(0, 4'd0, 0, 0, 0, 0, mk(4'd1, 0, 0, 1, 0));
    repeat (4) cyc(0, 4'd0, 0, 1, 0, 0, mk(4'd1, 0, 0, 1, 0));
    cyc(0, 4'd0, 0, 0, 0, 0, mk(4'd1, 0, 0, 1, 0));
    cyc(0, 4'd0, 0, 0, 0, 0, mk(4'd0, 1, 1, 0, 1));
    n = 0;
    while (sb.size() > 0 && obs_q.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL pause[%0d]: got %h required %h", n, o, e); else passed++;
      n++;
    end
  endtask

  task automatic test_load_zero_and_busy_load;
    obs_t e, o;
    int n;
    cyc(1, 4'd0, 0, 0, 0, 1, mk(4'd0, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, 0, 1, mk(4'd0, 1, 1, 0, 1));
    cyc(0, 4'd0, 0, 0, 0, 1, mk(4'd0, 0, 1, 0, 1));
    cyc(1, 4'd5, 0, 0, 0, 0, mk(4'd5, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, 0, 0, mk(4'd5, 0, 0, 1, 0));
    cyc(1, 4'd9, 0, 0, 0, 0, mk(4'd4, 0, 0, 1, 0));
    cyc(1, 4'd9, 1, 0, 0, 0, mk(4'd3, 0, 0, 1, 0));
    cyc(0, 4'd0, 0, 0, 1, 0, mk(4'd0, 0, 0, 0, 1));
    n = 0;
    while (sb.size() > 0 && obs_q.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL load_zero[%0d]: got %h required %h", n, o, e); else passed++;
      n++;
    end
  endtask

  task automatic test_abort_vs_load;
    obs_t e, o;
    int n;
    cyc(1, 4'd7, 0, 0, 0, 0, mk(4'd7, 0, 0, 0, 1));
    cyc(1, 4'd12, 0, 0, 0, 0, mk(4'd12, 0, 0, 0, 1));
    cyc(1, 4'd9, 0, 0, 1, 0, mk(4'd0, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, 0, 0, mk(4'd0, 0, 0, 0, 1));
    n = 0;
    while (sb.size() > 0 && obs_q.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL abort_load[%0d]: got %h required %h", n, o, e); else passed++;
      n++;
    end
  endtask

  task automatic test_max_load;
    obs_t e, o;
    int n;
    cyc(1, 4'd15, 0, 0, 0, 0, mk(4'd15, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, 0, 0, mk(4'd15, 0, 0, 1, 0));
    for (int k = 1; k <= 15; k++) begin
      cyc(0, 4'd0, 0, 0, 0, 0, mk(4'(15 - k), (k == 15), (k == 15), (k != 15), (k == 15)));
    end
    cyc(0, 4'd0, 0, 0, 0, 0, mk(4'd0, 0, 1, 0, 1));
    n = 0;
    while (sb.size() > 0 && obs_q.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL max_load[%0d]: got %h required %h", n, o, e); else passed++;
      n++;
    end
  endtask

  task automatic test_reset_mid_count;
    obs_t e, o;
    int n;
    cyc(1, 4'd10, 0, 0, 0, 0, mk(4'd10, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, 0, 0, mk(4'd10, 0, 0, 1, 0));
    cyc(0, 4'd0, 0, 0, 0, 0, mk(4'd9, 0, 0, 1, 0));
    cyc(0, 4'd0, 0, 0, 0, 0, mk(4'd8, 0, 0, 1, 0));
    n = 0;
    while (sb.size() > 0 && obs_q.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL mid_reset_pre[%0d]: got %h required %h", n, o, e); else passed++;
      n++;
    end
    #3 reset = 1'b0;
    #1;
    e = mk(4'd0, 0, 0, 0, 1); o = cur(); total++;
    if (o !== e) $display("FAIL mid_reset_async: got %h required %h", o, e); else passed++;
    @(posedge clk);
    #1;
    o = cur(); total++;
    if (o !== e) $display("FAIL mid_reset_held: got %h required %h", o, e); else passed++;
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 4'd0, 1, 0, 0, 0, mk(4'd0, 0, 0, 0, 1));
    cyc(0, 4'd0, 0, 0, 0, 0, mk(4'd0, 0, 0, 0, 1));
    n = 0;
    while (sb.size() > 0 && obs_q.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL mid_reset_post[%0d]: got %h required %h", n, o, e); else passed++;
      n++;
    end
  endtask

  initial begin
    test_reset;
    test_one_shot;
    test_periodic;
    test_pause;
    test_load_zero_and_busy_load;
    test_abort_vs_load;
    test_max_load;
    test_reset_mid_count;
    total++;
    if (sb.size() != 0 || obs_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d/%0d left required 0/0", sb.size(), obs_q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish by 50000 required finish");
    $fatal(1, "timeout");
  end

endmodule
